// File: rtl/sync_fifo_pkg.sv
// Shared defaults, occupancy type and parameter sanity helpers for the synchronous FIFO.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 16;

    typedef logic [$clog2(DEF_DEPTH):0] cnt_t;

    function automatic bit af_level_ok(input int unsigned af_level, input int unsigned depth);
        return (af_level >= 1) && (af_level <= depth);
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo; master drives requests, slave is the FIFO.
interface sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             write;
    logic [WIDTH-1:0] wdata;
    logic             read;
    logic [WIDTH-1:0] rdata;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write, wdata, read,
        input  rdata, empty, full, almost_full, count, overflow, underflow
    );

    modport slave (
        input  write, wdata, read,
        output rdata, empty, full, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read port.
module fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write word when both ports hit one slot (full FIFO, read+write).
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer/count/flag bookkeeping around fifo_mem, dropping illegal requests.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned DEPTH           = DEF_DEPTH,
    parameter int unsigned AF_LEVEL        = DEPTH - 2,
    parameter bit          CHECK_HANDSHAKE = 1'b0
) (
    input logic       clk,
    input logic       rst,
    sync_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (!af_level_ok(AF_LEVEL, DEPTH)) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL must lie in 1..DEPTH");
    end

    logic [CW-1:0] wptr_q, rptr_q, wptr_nxt, rptr_nxt;
    logic [CW-1:0] count_q, count_nxt;
    logic          empty_q, full_q, af_q, ovf_q, unf_q;
    logic          rd_ok, wr_ok;

    // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
    always_comb begin
        rd_ok     = bus.read && !empty_q;
        wr_ok     = bus.write && (!full_q || rd_ok);
        wptr_nxt  = wr_ok ? wptr_q + CW'(1) : wptr_q;
        rptr_nxt  = rd_ok ? rptr_q + CW'(1) : rptr_q;
        count_nxt = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_nxt;
            rptr_q  <= rptr_nxt;
            count_q <= count_nxt;
            empty_q <= (wptr_nxt == rptr_nxt);
            full_q  <= (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
            af_q    <= (count_nxt >= CW'(AF_LEVEL));
            ovf_q   <= bus.write && !wr_ok;
            unf_q   <= bus.read && empty_q;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok && !rst),
        .waddr (wptr_q[AW-1:0]),
        .wdata (bus.wdata),
        .re    (rd_ok && !rst),
        .raddr (rptr_q[AW-1:0]),
        .rdata (bus.rdata)
    );

    always_comb begin
        bus.empty       = empty_q;
        bus.full        = full_q;
        bus.almost_full = af_q;
        bus.count       = count_q;
        bus.overflow    = ovf_q;
        bus.underflow   = unf_q;
    end

    // Contract checks on the neighbours; off by default because the FIFO tolerates violations.
    if (CHECK_HANDSHAKE) begin : g_handshake_checks
        a_no_underflow: assert property (@(posedge clk) disable iff (rst) bus.read |-> !bus.empty);
        a_no_overflow:  assert property (@(posedge clk) disable iff (rst) bus.write |-> !bus.full || bus.read);
    end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed vector table plus a queue-modelled streaming phase for sync_fifo (WIDTH=8, DEPTH=16).
module tb_sync_fifo;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned AF = 14;

    typedef struct packed {
        logic [7:0] rdata;
        logic       empty;
        logic       full;
        logic       af;
        logic [4:0] count;
        logic       ovf;
        logic       unf;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  wr;
        logic  rd;
        logic  [7:0] wd;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sync_fifo #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic vec_t mk(input logic r, input logic wr, input logic rd, input logic [7:0] wd,
                                input logic [7:0] rdata, input int cnt, input logic ovf, input logic unf);
        vec_t v;
        v.rst       = r;
        v.wr        = wr;
        v.rd        = rd;
        v.wd        = wd;
        v.exp.rdata = rdata;
        v.exp.count = 5'(cnt);
        v.exp.empty = (cnt == 0);
        v.exp.full  = (cnt == int'(D));
        v.exp.af    = (cnt >= int'(AF));
        v.exp.ovf   = ovf;
        v.exp.unf   = unf;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        outs_t act;
        rst       = v.rst;
        bus.write = v.wr;
        bus.read  = v.rd;
        bus.wdata = v.wd;
        @(posedge clk);
        #1;
        act = '{bus.rdata, bus.empty, bus.full, bus.almost_full, bus.count, bus.overflow, bus.underflow};
        vectors++;
        if (act !== v.exp) begin
            miscompares++;
            $display("FAIL %s: got rdata=%h empty=%b full=%b af=%b count=%0d ovf=%b unf=%b, required rdata=%h empty=%b full=%b af=%b count=%0d ovf=%b unf=%b",
                     name, act.rdata, act.empty, act.full, act.af, act.count, act.ovf, act.unf,
                     v.exp.rdata, v.exp.empty, v.exp.full, v.exp.af, v.exp.count, v.exp.ovf, v.exp.unf);
        end
    endtask

    vec_t       tbl[$];
    logic [7:0] q[$];
    logic [7:0] exp_rdata;
    logic [7:0] wd;
    logic       rd, wr;
    int         written, cycles;

    initial begin
        rst       = 1'b1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        bus.wdata = '0;

        // Reset held for two cycles, then released idle.
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        // Underflow for two back-to-back reads, then the pulse clears.
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        // Fill with 0x01..0x10.
        for (int k = 1; k <= 16; k++)
            tbl.push_back(mk(0, 1, 0, 8'(k), 8'h00, k, 0, 0));
        // Two overflowing writes of 0xAA, then the pulse clears.
        tbl.push_back(mk(0, 1, 0, 8'hAA, 8'h00, 16, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'hAA, 8'h00, 16, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 16, 0, 0));
        // Full with read+write 0x55: oldest word out, count stays at DEPTH.
        tbl.push_back(mk(0, 1, 1, 8'h55, 8'h01, 16, 0, 0));
        // Drain: 0x02..0x10 then 0x55, never 0xAA.
        for (int k = 2; k <= 16; k++)
            tbl.push_back(mk(0, 0, 1, 8'h00, 8'(k), 17 - k, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h55, 0, 0, 0));
        // Read of empty FIFO keeps rdata.
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h55, 0, 0, 1));
        // Empty with read+write: write taken, read rejected.
        tbl.push_back(mk(0, 1, 1, 8'h77, 8'h55, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h77, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h77, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Streaming phase: 40 words with random legal reads/writes, checked against a queue.
        exp_rdata = 8'h77;
        written   = 0;
        cycles    = 0;
        while ((written < 40 || q.size() != 0) && cycles < 2000) begin
            rd = (q.size() != 0) && ($urandom_range(0, 1) == 1);
            wr = (written < 40) && (q.size() < int'(D) || rd) && ($urandom_range(0, 2) != 0);
            wd = 8'(8'hC0 + written);
            if (rd) exp_rdata = q.pop_front();
            if (wr) begin
                q.push_back(wd);
                written++;
            end
            apply(mk(0, wr, rd, wd, exp_rdata, q.size(), 0, 0), $sformatf("stream%0d", cycles));
            cycles++;
        end
        vectors++;
        if (cycles >= 2000) begin
            miscompares++;
            $display("FAIL stream_budget: got %0d words written, required 40 within 2000 cycles", written);
        end

        // Five words in, then reset mid-stream with both requests asserted.
        for (int k = 1; k <= 5; k++)
            apply(mk(0, 1, 0, 8'(8'h30 + k), exp_rdata, k, 0, 0), $sformatf("refill%0d", k));
        apply(mk(1, 1, 1, 8'hEE, 8'h00, 0, 0, 0), "mid_reset");
        apply(mk(0, 0, 1, 8'h00, 8'h00, 0, 0, 1), "post_reset_read");
        apply(mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0), "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
